// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types and constants for the UART receiver core:
//   rx_state_t  - receiver FSM state encoding
//   PAR_*       - parity_mode encodings (2'b11 behaves as PAR_NONE)
//   majority3   - 2-of-3 vote used by the bit sampler
//   parity_on   - true when a mode carries a parity bit
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the UART receiver: brings the asynchronous line into the clk
// domain, flags 1-to-0 transitions and votes each bit from three samples
// taken around the bit centre.
//   clk, rst      - clock, asynchronous active-high reset
//   rx            - raw serial line (asynchronous, idles high)
//   cnt           - bit-phase counter owned by the core FSM
//   fall          - synchronized line went 1 -> 0 this cycle
//   sample_point  - cnt is at the third (deciding) sample position
//   vote          - majority of the three samples, valid with sample_point
// -----------------------------------------------------------------------------
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [CNT_W-1:0] cnt,
  output logic             fall,
  output logic             sample_point,
  output logic             vote
);

  localparam logic [CNT_W-1:0] SAMP_A = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] SAMP_B = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] SAMP_C = CNT_W'(CLKS_PER_BIT / 2 + 1);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       samp_a_q;
  logic       samp_b_q;
  logic       rx_sync;

  assign rx_sync = sync_q[1];

  // Synchronizer and edge history reset to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  // NOTE: every clocked register here uses <= so all flops update from the
  // values present before the edge; with = the two sync stages would collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= rx_sync;
      if (cnt == SAMP_A) samp_a_q <= rx_sync;
      if (cnt == SAMP_B) samp_b_q <= rx_sync;
    end
  end

  assign fall         = prev_q & ~rx_sync;
  assign sample_point = (cnt == SAMP_C);
  // Third sample is the live value, so the decision is available in the same
  // cycle as the last sample rather than one cycle later.
  assign vote         = majority3(samp_a_q, samp_b_q, rx_sync);

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// UART receiver: start detect, DATA_W data bits LSB first, optional even/odd
// parity, one or two stop bits, and a single-entry valid/ready output register.
//   clk, rst      - clock, asynchronous active-high reset
//   en            - receiver enable; low aborts any frame in progress
//   rx            - serial line (asynchronous, idles high)
//   parity_mode   - 00 none, 01 even, 10 odd, 11 none (latched per frame)
//   stop2         - 0 one stop bit, 1 two stop bits (latched per frame)
//   data          - held received word
//   valid/ready   - output handshake; transfer when both high at an edge
//   parity_err    - parity mismatch for the held word
//   frame_err     - a checked stop bit was low for the held word
//   overrun       - one-cycle pulse when a finished frame is dropped
//   busy          - FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(DATA_W - 1);

  rx_state_t         state_q, state_next;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bit_idx_q;
  logic [DATA_W-1:0] shreg_q;
  logic [1:0]        mode_q;
  logic              stop2_q;
  logic              stop_idx_q;
  logic              perr_q;
  logic              ferr_q;

  logic fall;
  logic decide;
  logic vote;
  logic bit_end;
  logic start_frame;
  logic finish;

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .cnt          (cnt_q),
    .fall         (fall),
    .sample_point (decide),
    .vote         (vote)
  );

  assign bit_end = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_next;
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next  = state_q;
    start_frame = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        // fall only fires after the line has been seen high, which also keeps
        // a held-low (break) line from retriggering.
        if (en && fall) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (decide && vote) state_next = IDLE;
        else if (bit_end)   state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx_q == LAST_BIT))
          state_next = parity_on(mode_q) ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        // Leave at the decision of the last stop bit so a start bit that
        // follows immediately is still caught on its leading edge.
        if (decide && (!stop2_q || stop_idx_q)) begin
          state_next = IDLE;
          finish     = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next  = IDLE;
      start_frame = 1'b0;
      finish      = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Bit timing, shift register and pending flags
  // ---------------------------------------------------------------------------
  // NOTE: the shift register and flags are reset along with the control state
  // so that nothing downstream can observe X from a frame that never ran.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      mode_q     <= PAR_NONE;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // Every non-idle transition happens at a bit end, so the counter only
      // needs clearing there and whenever we are in or heading to IDLE.
      if (state_q == IDLE || state_next == IDLE || bit_end) cnt_q <= '0;
      else                                                 cnt_q <= cnt_q + 1'b1;

      if (start_frame) begin
        mode_q     <= parity_mode;
        stop2_q    <= stop2;
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
      end

      case (state_q)
        DATA: begin
          if (decide)  shreg_q   <= {vote, shreg_q[DATA_W-1:1]};
          if (bit_end) bit_idx_q <= bit_idx_q + 4'd1;
        end
        PARITY: begin
          // Even needs XOR(data, parity) == 0, odd needs 1.
          if (decide) perr_q <= (^shreg_q) ^ vote ^ (mode_q == PAR_ODD);
        end
        STOP: begin
          if (decide && !vote) ferr_q     <= 1'b1;
          if (bit_end)         stop_idx_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  // The last stop vote is folded in directly because it is decided in the
  // same cycle the word is committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (finish && valid && !ready) begin
        overrun <= 1'b1;
      end else if (finish) begin
        data       <= shreg_q;
        parity_err <= perr_q;
        frame_err  <= ferr_q | ~vote;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_W, 8: data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, 16: clk cycles per bit; even; minimum 8.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  receiver enable.
REQ-006 rx  input  1  serial line; asynchronous to clk; idles high.
REQ-007 parity_mode  input  2  selects 00 none, 01 even, 10 odd; 11 treated as none.
REQ-008 stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-009 data  output  DATA_W  received word; LSB is the first data bit received.
REQ-010 valid  output  1  data and error flags are held valid.
REQ-011 ready  input  1  consumer accepts; transfer occurs when valid and ready are both high on a clock edge.
REQ-012 parity_err  output  1  parity mismatch flag for the held word.
REQ-013 frame_err  output  1  stop-bit-low flag for the held word.
REQ-014 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-015 busy  output  1  FSM not in IDLE.

Function
REQ-016 rx passes through a 2-flop synchronizer; all rx references below mean the synchronized value, which lags rx by 2 cycles.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE to START on a 1-to-0 transition while en=1.
- START to DATA; DATA to PARITY or STOP.
- PARITY to STOP.
- STOP to IDLE.
REQ-018 A bit counter resets on entry to each bit; the bit is sampled by a 3-sample majority at counts CLKS_PER_BIT/2-1, CLKS_PER_BIT/2 and CLKS_PER_BIT/2+1.
REQ-019 START: if the majority value is 1, the start is false; the FSM returns to IDLE and produces no output.
REQ-020 DATA: exactly DATA_W bits are shifted in, LSB first.
REQ-021 PARITY: entered only when the latched mode is even or odd.
- Even: the XOR of the data bits and the parity bit must be 0.
- Odd: that XOR must be 1.
- A mismatch sets the pending parity_err.
REQ-022 parity_mode and stop2 are latched at START entry; changes mid-frame take effect on the next frame.
REQ-023 STOP: a majority value of 0 on the first stop bit sets the pending frame_err.
- With stop2=1, the second stop bit is also checked; 0 sets frame_err.
REQ-024 The FSM returns to IDLE at the decision cycle of the last stop bit, without waiting for the bit end, so back-to-back frames are received.
REQ-025 The cycle after the final stop decision is the load cycle: data, parity_err and frame_err load into the output register and valid=1.
REQ-026 Output register contents are stable while valid=1 and ready=0.
REQ-027 valid clears on a clock edge where valid=1 and ready=1, unless a new load occurs in the same cycle; load takes priority and valid stays 1.
REQ-028 At the load cycle, if valid=1 and ready=0, the new frame is discarded, the held word is retained, and overrun=1 for exactly that cycle.
REQ-029 When en=0, the FSM goes to IDLE at the next edge and any in-progress frame is discarded without flags; the output register and handshake are unaffected.
REQ-030 A line held low (break) produces one frame with data=0 and frame_err=1; no new start is detected until rx has been seen high.

Reset
REQ-031 While rst=1:
- FSM is IDLE and counters are 0.
- data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Synchronizer flops are 1.
REQ-032 Reset asserted mid-frame aborts the frame immediately; after release the receiver waits for a fresh 1-to-0 edge.

Structure
REQ-033 Package uart_rx_pkg holds:
- the FSM state enum;
- parity-mode constants PAR_NONE, PAR_EVEN, PAR_ODD.
REQ-034 One sub-module, uart_rx_sampler, contains the 2-flop synchronizer, the falling-edge detect and the 3-sample majority voter; the FSM, shift register and output register stay in uart_rx_core.

Verification
REQ-035 Setup: CLKS_PER_BIT=16, DATA_W=8, even parity, ready=1. Stimulus: send 0xA5 with parity bit 0. Required: data=0xA5, valid for 1 cycle, no flags.
REQ-036 Same setup. Stimulus: send 0xD5 (bits 1,0,1,0,1,0,1,1) with parity bit 0. Required: data=0xD5, parity_err=1.
REQ-037 Parity none. Stimulus: send 0x3C with stop bit 0. Required: frame_err=1, data=0x3C. Then send 0x3C with stop2=1, first stop bit 1 and second stop bit 0. Required: frame_err=1.
REQ-038 ready=0. Stimulus: send 0x11 then 0x22 back-to-back. Required: data stays 0x11, overrun pulses once at the second load, valid stays 1. Raising ready then clears valid.
REQ-039 Stimulus: a 4-cycle low glitch on idle rx. Required: no valid; busy returns to 0 within 12 cycles.
REQ-040 Stimulus: assert rst during bit 3 of a frame, then send 0x5A. Required: only 0x5A is delivered, without flags. Repeating the abort with en=0 instead of rst gives the same result.
